pll_phase_ctrl: RTL and testbench



---
 rtl/pll_ctrl_pkg.sv | 29 ++
 rtl/pll_phase_ctrl_sync_bit.sv | 35 +++
 rtl/pll_phase_ctrl.sv | 136 +++++++++++++
 tb/tb_pll_phase_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift controller.
package pll_ctrl_pkg;

  localparam int PLL_NUM_OUT = 5;
  localparam int SEL_W       = 3;
  localparam int MAX_STEP_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP_S,
    WAIT_LOCK,
    FINISH
  } ctrl_state_e;

  // steps is sized for the widest STEP_W the top accepts; narrower counts are zero-extended
  typedef struct packed {
    logic                  load;
    logic [SEL_W-1:0]      sel;
    logic                  dir;
    logic [MAX_STEP_W-1:0] steps;
  } phase_cmd_t;

  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return ({29'd0, sel} < 32'(PLL_NUM_OUT));
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_sync_bit.sv
// Single-bit flop-chain synchronizer with synchronous reset; STAGES edges of latency, no backpressure.
// q_nxt exposes the value the last flop loads next, so consumers can register against it without an extra stage.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_nxt
);

  logic [STAGES-1:0] ff;
  logic [STAGES-1:0] ff_d;

  generate
    if (STAGES == 1) begin : g_one
      assign ff_d = d;
    end else begin : g_chain
      assign ff_d = {ff[STAGES-2:0], d};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= ff_d;
    end
  end

  assign q     = ff[STAGES-1];
  assign q_nxt = ff_d[STAGES-1];

endmodule

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the audio PLL: N step pulses or one load pulse, then wait for lock; all outputs registered.
// First pulse starts two cycles after accept; cmd_ready stays low while busy or while the PLL is unlocked, so commands wait upstream.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int STEP_W       = 8,
  parameter int PULSE_LOW    = 2,
  parameter int GAP          = 4,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_sel,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              pll_lock,
  output logic              lock_sync,
  output logic [2:0]        phase_sel,
  output logic              phase_dir,
  output logic              phase_step_n,
  output logic              load_phase
);

  localparam int TMR_MAX_A = (PULSE_LOW > GAP) ? PULSE_LOW : GAP;
  localparam int TMR_MAX   = (LOCK_TIMEOUT > TMR_MAX_A) ? LOCK_TIMEOUT : TMR_MAX_A;
  localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  ctrl_state_e      state_q, state_d;
  phase_cmd_t       cmd_q;
  logic [TMR_W-1:0] tmr_q;
  logic             lock_nxt;
  logic             fin_err;
  logic             accept;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (pll_lock),
    .q    (lock_sync),
    .q_nxt(lock_nxt)
  );

  // cmd_ready is only ever high in IDLE, so this also implies state_q == IDLE
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    fin_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        if (!sel_legal(cmd_q.sel)) begin
          state_d = FINISH;
          fin_err = 1'b1;
        end else if (!cmd_q.load && cmd_q.steps == '0) begin
          state_d = FINISH;
        end else begin
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (tmr_q == TMR_W'(PULSE_LOW - 1)) state_d = GAP_S;
      end
      GAP_S: begin
        if (tmr_q == TMR_W'(GAP - 1)) begin
          if (!cmd_q.load && cmd_q.steps > MAX_STEP_W'(1)) state_d = PULSE;
          else state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = FINISH;
        end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          state_d = FINISH;
          fin_err = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      tmr_q        <= '0;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      phase_sel    <= '0;
      phase_dir    <= 1'b0;
      phase_step_n <= 1'b1;
      load_phase   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Timer restarts on every state change, so each phase counts from 0
      if (state_d != state_q || state_q == IDLE) tmr_q <= '0;
      else tmr_q <= tmr_q + TMR_W'(1);

      if (accept) begin
        cmd_q     <= '{load: cmd_load, sel: cmd_sel, dir: cmd_dir, steps: MAX_STEP_W'(cmd_steps)};
        phase_sel <= cmd_sel;
        phase_dir <= cmd_dir;
      end else if (state_q == GAP_S && state_d != GAP_S && !cmd_q.load) begin
        cmd_q.steps <= cmd_q.steps - MAX_STEP_W'(1);
      end

      // Outputs are registered from the next state so they line up with it
      cmd_ready    <= (state_d == IDLE) && lock_nxt;
      busy         <= (state_d != IDLE);
      done         <= (state_d == FINISH) && !fin_err;
      err          <= (state_d == FINISH) && fin_err;
      phase_step_n <= !((state_d == PULSE) && !cmd_q.load);
      load_phase   <= (state_d == PULSE) && cmd_q.load;
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: directed scenarios plus randomized commands against a cycle-offset model.
module tb_pll_phase_ctrl;

  localparam int STEP_W       = 8;
  localparam int PULSE_LOW    = 2;
  localparam int GAP          = 4;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int SYNC_STAGES  = 2;
  localparam int PER          = PULSE_LOW + GAP;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_load, cmd_dir;
  logic [2:0]        cmd_sel;
  logic [STEP_W-1:0] cmd_steps;
  logic              busy, done, err, pll_lock, lock_sync;
  logic [2:0]        phase_sel;
  logic              phase_dir, phase_step_n, load_phase;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pll_phase_ctrl #(
    .STEP_W(STEP_W), .PULSE_LOW(PULSE_LOW), .GAP(GAP),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_sel(cmd_sel), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .busy(busy), .done(done), .err(err), .pll_lock(pll_lock), .lock_sync(lock_sync),
    .phase_sel(phase_sel), .phase_dir(phase_dir), .phase_step_n(phase_step_n),
    .load_phase(load_phase)
  );

  // Reference model: everything is expressed as an offset k in cycles after the accepting edge, lock held high.
  function automatic bit m_illegal(int sel);
    return sel >= 5;
  endfunction

  function automatic int m_npulses(bit load, int sel, int steps);
    if (m_illegal(sel)) return 0;
    return load ? 1 : steps;
  endfunction

  function automatic int m_end(bit load, int sel, int steps);
    if (m_illegal(sel) || (!load && steps == 0)) return 2;
    return 3 + m_npulses(load, sel, steps) * PER;
  endfunction

  function automatic bit m_pulse_on(int k, int n);
    if (k < 2) return 1'b0;
    return ((k - 2) / PER < n) && ((k - 2) % PER < PULSE_LOW);
  endfunction

  // Returns at the falling edge of cycle T+1 when the command was accepted at edge T
  task automatic send_cmd(input bit load, input int sel, input bit dir, input int steps,
                          input int budget, output bit ok);
    cmd_load  = load;
    cmd_sel   = 3'(sel);
    cmd_dir   = dir;
    cmd_steps = STEP_W'(steps);
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (cmd_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: cmd_ready never rose within %0d cycles (required 1)", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_lock = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0;
    cmd_sel = '0; cmd_dir = 1'b0; cmd_steps = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, done, err, lock_sync, phase_sel, phase_dir, phase_step_n, load_phase} !== 11'b00000_000_010) begin
      miscompares++;
      $display("FAIL reset_values: got %b required 00000_000_010",
               {cmd_ready, busy, done, err, lock_sync, phase_sel, phase_dir, phase_step_n, load_phase});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({lock_sync, cmd_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL sync_one_edge: lock_sync,cmd_ready=%b required 00", {lock_sync, cmd_ready});
    end
    @(negedge clk);
    vectors++;
    if ({lock_sync, cmd_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL sync_two_edges: lock_sync,cmd_ready=%b required 11", {lock_sync, cmd_ready});
    end
  endtask

  task automatic test_basic_steps();
    bit ok;
    int starts[$];
    int run = 0, bad_w = 0, done_k = -1, err_seen = 0, hold_bad = 0;
    logic prev = 1'b1;
    send_cmd(1'b0, 2, 1'b1, 3, 50, ok);
    for (int k = 1; k <= 40; k++) begin
      if (phase_step_n === 1'b0 && prev === 1'b1) starts.push_back(k);
      if (phase_step_n === 1'b0) run++;
      else begin
        if (prev === 1'b0 && run != PULSE_LOW) bad_w++;
        run = 0;
      end
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (err !== 1'b0) err_seen++;
      if (phase_sel !== 3'd2 || phase_dir !== 1'b1) hold_bad++;
      prev = phase_step_n;
      @(negedge clk);
    end
    vectors++;
    if (starts.size() != 3) begin
      miscompares++;
      $display("FAIL basic_pulse_count: got %0d required 3", starts.size());
    end
    for (int i = 0; i < starts.size() && i < 3; i++) begin
      vectors++;
      if (starts[i] != 2 + i * PER) begin
        miscompares++;
        $display("FAIL basic_pulse_start[%0d]: cycle %0d required %0d", i, starts[i], 2 + i * PER);
      end
    end
    vectors++;
    if (bad_w != 0) begin
      miscompares++;
      $display("FAIL basic_pulse_width: %0d pulses not %0d cycles wide (required 0)", bad_w, PULSE_LOW);
    end
    vectors++;
    if (done_k != 3 + 3 * PER) begin
      miscompares++;
      $display("FAIL basic_done_cycle: T+%0d required T+%0d", done_k, 3 + 3 * PER);
    end
    vectors++;
    if (hold_bad != 0 || err_seen != 0) begin
      miscompares++;
      $display("FAIL basic_sel_dir_err: sel/dir wrong %0d cycles, err %0d cycles (required 0,0)", hold_bad, err_seen);
    end
  endtask

  task automatic test_load();
    bit ok;
    int lp_cnt = 0, lp_first = -1, sn_low = 0, done_k = -1, err_seen = 0;
    send_cmd(1'b1, 0, 1'b0, int'($urandom_range(0, 255)), 50, ok);
    for (int k = 1; k <= 20; k++) begin
      if (load_phase === 1'b1) begin
        lp_cnt++;
        if (lp_first < 0) lp_first = k;
      end
      if (phase_step_n !== 1'b1) sn_low++;
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (err !== 1'b0) err_seen++;
      @(negedge clk);
    end
    vectors++;
    if (lp_cnt != PULSE_LOW || lp_first != 2) begin
      miscompares++;
      $display("FAIL load_pulse: %0d cycles from T+%0d required %0d from T+2", lp_cnt, lp_first, PULSE_LOW);
    end
    vectors++;
    if (sn_low != 0 || err_seen != 0) begin
      miscompares++;
      $display("FAIL load_side_effects: step_n low %0d, err %0d cycles (required 0,0)", sn_low, err_seen);
    end
    vectors++;
    if (done_k != 3 + PER) begin
      miscompares++;
      $display("FAIL load_done_cycle: T+%0d required T+%0d", done_k, 3 + PER);
    end
  endtask

  task automatic test_edge_cmds();
    bit ok;
    bit t_load[3]  = '{1'b0, 1'b0, 1'b1};
    int t_sel[3]   = '{1, 5, 7};
    int t_steps[3] = '{0, 3, 0};
    for (int t = 0; t < 3; t++) begin
      int done_k = -1, err_k = -1, pulses = 0;
      bit want_err = m_illegal(t_sel[t]);
      send_cmd(t_load[t], t_sel[t], 1'b0, t_steps[t], 50, ok);
      for (int k = 1; k <= 8; k++) begin
        if (done === 1'b1) done_k = k;
        if (err === 1'b1) err_k = k;
        if (phase_step_n !== 1'b1 || load_phase !== 1'b0) pulses++;
        @(negedge clk);
      end
      vectors++;
      if ((want_err ? err_k : done_k) != 2 || (want_err ? done_k : err_k) != -1 || pulses != 0) begin
        miscompares++;
        $display("FAIL edge_cmd[%0d]: done at %0d err at %0d pulse cycles %0d (required %s at 2, no pulses)",
                 t, done_k, err_k, pulses, want_err ? "err" : "done");
      end
    end
  endtask

  task automatic test_random_commands(input int count);
    bit ok;
    for (int c = 0; c < count; c++) begin
      bit load = ($urandom_range(0, 3) == 0);
      int sel  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      bit dir  = 1'($urandom_range(0, 1));
      int steps = int'($urandom_range(0, 6));
      int kend = m_end(load, sel, steps);
      int n = m_npulses(load, sel, steps);
      send_cmd(load, sel, dir, steps, 50, ok);
      for (int k = 1; k <= kend + 1; k++) begin
        logic [8:0] expv, obs;
        expv = {!(!load && m_pulse_on(k, n)), load && m_pulse_on(k, n), k <= kend,
                (k == kend) && !m_illegal(sel), (k == kend) && m_illegal(sel), 3'(sel), dir};
        obs = {phase_step_n, load_phase, busy, done, err, phase_sel, phase_dir};
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL rand[%0d] load=%0d sel=%0d steps=%0d T+%0d: stepn,lp,busy,done,err,sel,dir=%b required %b",
                   c, load, sel, steps, k, obs, expv);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_max_steps();
    bit ok;
    int pulses = 0, done_k = -1;
    int max_n = (1 << STEP_W) - 1;
    logic prev = 1'b1;
    send_cmd(1'b0, 4, 1'b0, max_n, 50, ok);
    for (int k = 1; k <= 6 + max_n * PER; k++) begin
      if (phase_step_n === 1'b0 && prev === 1'b1) pulses++;
      if (done === 1'b1 && done_k < 0) done_k = k;
      prev = phase_step_n;
      @(negedge clk);
    end
    vectors++;
    if (pulses != max_n || done_k != 3 + max_n * PER) begin
      miscompares++;
      $display("FAIL max_steps: %0d pulses done at T+%0d required %0d pulses done at T+%0d",
               pulses, done_k, max_n, 3 + max_n * PER);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc_k = -1, done_k = -1;
    send_cmd(1'b0, 3, 1'b0, 2, 50, ok);
    cmd_load = 1'b0; cmd_sel = 3'd1; cmd_dir = 1'b1; cmd_steps = 8'd1;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 60 && acc_k < 0; k++) begin
      if (cmd_ready === 1'b1) acc_k = k;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    vectors++;
    if (acc_k != m_end(1'b0, 3, 2) + 1) begin
      miscompares++;
      $display("FAIL b2b_accept: second command accepted at A+%0d required A+%0d", acc_k, m_end(1'b0, 3, 2) + 1);
    end
    vectors++;
    if (phase_sel !== 3'd1 || phase_dir !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_sel: sel=%0d dir=%b required 1,1", phase_sel, phase_dir);
    end
    for (int k = 1; k <= 20; k++) begin
      if (done === 1'b1 && done_k < 0) done_k = k;
      @(negedge clk);
    end
    vectors++;
    if (done_k != m_end(1'b0, 1, 1)) begin
      miscompares++;
      $display("FAIL b2b_done: T+%0d required T+%0d", done_k, m_end(1'b0, 1, 1));
    end
  endtask

  task automatic test_lock_restore();
    bit ok;
    int w = 2 + 2 * PER;
    int kr = w + 100;
    int done_k = -1, err_seen = 0, pulses = 0;
    logic prev = 1'b1;
    send_cmd(1'b0, 0, 1'b1, 2, 50, ok);
    for (int k = 1; k <= kr + 20; k++) begin
      if (phase_step_n === 1'b0 && prev === 1'b1) pulses++;
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (err !== 1'b0) err_seen++;
      prev = phase_step_n;
      if (k == 3) pll_lock = 1'b0;
      if (k == kr) pll_lock = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (pulses != 2) begin
      miscompares++;
      $display("FAIL lock_drop_pulses: %0d pulses required 2", pulses);
    end
    vectors++;
    if (done_k != kr + SYNC_STAGES + 1 || err_seen != 0) begin
      miscompares++;
      $display("FAIL lock_restore: done at T+%0d err cycles %0d required done at T+%0d no err",
               done_k, err_seen, kr + SYNC_STAGES + 1);
    end
  endtask

  task automatic test_lock_timeout();
    bit ok;
    int w = 2 + PER;
    int err_k = -1, err_cnt = 0, done_seen = 0;
    send_cmd(1'b0, 1, 1'b0, 1, 50, ok);
    for (int k = 1; k <= w + LOCK_TIMEOUT + 4; k++) begin
      if (err === 1'b1) begin
        err_cnt++;
        if (err_k < 0) err_k = k;
      end
      if (done !== 1'b0) done_seen++;
      if (k == 4) pll_lock = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (err_k != w + LOCK_TIMEOUT || err_cnt != 1 || done_seen != 0) begin
      miscompares++;
      $display("FAIL lock_timeout: err at T+%0d (%0d cycles) done %0d required err once at T+%0d no done",
               err_k, err_cnt, done_seen, w + LOCK_TIMEOUT);
    end
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL unlocked_ready: cmd_ready=%b required 0", cmd_ready);
    end
    pll_lock = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int evt = 0;
    send_cmd(1'b0, 2, 1'b0, 4, 50, ok);
    for (int k = 1; k < 2 + PER; k++) @(negedge clk);
    vectors++;
    if (phase_step_n !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_pre: phase_step_n=%b in 2nd pulse required 0", phase_step_n);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({phase_step_n, load_phase, busy, done, err} !== 5'b10000) begin
      miscompares++;
      $display("FAIL rst_mid: stepn,lp,busy,done,err=%b required 10000",
               {phase_step_n, load_phase, busy, done, err});
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done !== 1'b0 || err !== 1'b0 || phase_step_n !== 1'b1) evt++;
      @(negedge clk);
    end
    vectors++;
    if (evt != 0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_after: %0d stray cycles, cmd_ready=%b required 0 stray and ready 1", evt, cmd_ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_steps();
    test_load();
    test_edge_cmds();
    test_random_commands(16);
    test_max_steps();
    test_back_to_back();
    test_lock_restore();
    test_lock_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
